shift_cmd_sequencer: RTL

- Upstream command source for the N-bit shift_register stage.
- Buffers {ctrl, data} commands in a small FIFO.
- Issues commands one at a time as single-cycle strobes, either free-running at a programmable prescaled rate or one per step pulse.
- The top level gates the shift stage with cmd_valid, so the shift register acts only on issued commands.

---
 rtl/shift_ctrl_pkg.sv | 30 +++
 rtl/cmd_fifo.sv | 63 ++++++
 rtl/shift_cmd_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift_register command path.
//   - shift_op_e  : 3-bit opcode encodings understood by shift_register
//   - shift_cmd_t : {ctrl, data} command word at the default data width
//   - seq_mode_e  : sequencer issue mode (IDLE = step mode, RUN = free-run)
package shift_ctrl_pkg;

  localparam int unsigned SHIFT_N = 8;

  typedef enum logic [2:0] {
    CLR   = 3'd0,
    LOAD  = 3'd1,
    LSR   = 3'd2,
    LSL   = 3'd3,
    ASR   = 3'd4,
    SIN_L = 3'd5,
    ROR   = 3'd6,
    ROL   = 3'd7
  } shift_op_e;

  typedef struct packed {
    shift_op_e            ctrl;
    logic [SHIFT_N-1:0]   data;
  } shift_cmd_t;

  typedef enum logic {
    MODE_IDLE = 1'b0,
    MODE_RUN  = 1'b1
  } seq_mode_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with occupancy count.
//   clk, rst     : clock, synchronous active-high reset (clears pointers/count)
//   i_push       : write request, ignored when full
//   i_wdata      : write data
//   i_pop        : read request, ignored when empty
//   o_rdata      : current head entry (valid when !o_empty)
//   o_full/o_empty/o_count : status
module cmd_fifo #(
  parameter int unsigned W     = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_wdata,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer feeding the shift_register stage.
// Buffers {ctrl, data} commands and issues them one at a time as a
// single-cycle cmd_valid strobe, either at a prescaled rate (run=1) or one
// per rising edge of step (run=0).
//   clk, rst          : clock, synchronous active-high reset
//   wr_valid/wr_ready : push handshake (wr_ready = FIFO not full)
//   wr_ctrl, wr_data  : command to push
//   run, step, div    : issue mode, step input, prescaler terminal count
//   cmd_valid/ctrl/data : registered issue strobe and command
//   fifo_count, busy  : occupancy, run with work pending
module shift_cmd_sequencer
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV_W = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [2:0]                   wr_ctrl,
  input  logic [N-1:0]                 wr_data,
  input  logic                         run,
  input  logic                         step,
  input  logic [DIV_W-1:0]             div,
  output logic                         cmd_valid,
  output logic [2:0]                   cmd_ctrl,
  output logic [N-1:0]                 cmd_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         busy
);

  localparam int unsigned CMD_W = 3 + N;

  logic [DIV_W-1:0] r_cnt;
  logic             r_step_d;
  logic [CMD_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_tick;
  logic             w_step_evt;
  seq_mode_e        w_mode;

  assign w_mode   = run ? MODE_RUN : MODE_IDLE;
  assign wr_ready = ~w_full;
  assign busy     = run & ~w_empty;
  assign w_push   = wr_valid & ~w_full;

  always_comb begin
    w_tick     = 1'b0;
    w_step_evt = 1'b0;
    unique case (w_mode)
      MODE_RUN:  w_tick     = (r_cnt == div);
      MODE_IDLE: w_step_evt = step & ~r_step_d;
    endcase
  end

  // Pop sees only entries present before this edge, so a push into an
  // empty FIFO is never issued in the same cycle.
  assign w_pop = (w_tick | w_step_evt) & ~w_empty;

  cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({wr_ctrl, wr_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_step_d  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_ctrl  <= '0;
      cmd_data  <= '0;
    end else begin
      r_step_d <= step;
      // Count is parked at 0 outside RUN so a new run always starts fresh.
      if (w_mode == MODE_RUN && !w_tick) begin
        r_cnt <= r_cnt + DIV_W'(1);
      end else begin
        r_cnt <= '0;
      end
      cmd_valid <= w_pop;
      if (w_pop) begin
        {cmd_ctrl, cmd_data} <= w_head;
      end
    end
  end

endmodule
